// File: rtl/motion_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// motion_alarm_ctrl
//
// Consumer end of the PIR sensor interface. Each of the three PIR levels is
// compared against a threshold. A run of motion must last for CONFIRM_CYCLES
// consecutive cycles before the controller raises a latched alarm. The alarm
// records which zones took part in the confirming run. The controller arms
// through an exit delay, and the user can disarm it or acknowledge an alarm.
//
// Parameters
//   THRESHOLD       sensor level counted as motion (level >= THRESHOLD)
//   CONFIRM_CYCLES  consecutive motion cycles needed to raise alarm (1..15)
//   ARM_DELAY       exit-delay cycles spent in ARMING (0..15)
//
// Ports
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   turn          in   1  system enable; 1 = armed request, 0 = disarm
//   stop_alarm    in   1  user acknowledge; clears an active alarm
//   pir_sensor_1  in   7  PIR level, zone 0
//   pir_sensor_2  in   7  PIR level, zone 1
//   pir_sensor_3  in   7  PIR level, zone 2
//   armed         out  1  1 in ARMED / CONFIRM / ALARM
//   alarm         out  1  1 only in ALARM
//   zone          out  3  zones seen in the confirming run (bit0 = sensor_1)
//   alarm_count   out  8  alarms raised since reset, saturating at 8'hFF
//   state         out  3  encoded FSM state for debug
// ---------------------------------------------------------------------------
module motion_alarm_ctrl #(
    parameter logic [6:0]  THRESHOLD      = 7'd20,
    parameter int unsigned CONFIRM_CYCLES = 3,
    parameter int unsigned ARM_DELAY      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turn,
    input  logic       stop_alarm,
    input  logic [6:0] pir_sensor_1,
    input  logic [6:0] pir_sensor_2,
    input  logic [6:0] pir_sensor_3,
    output logic       armed,
    output logic       alarm,
    output logic [2:0] zone,
    output logic [7:0] alarm_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMING  = 3'd1,
        S_ARMED   = 3'd2,
        S_CONFIRM = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    // The last value of each counter before its transition fires.
    localparam logic [3:0] DLY_LAST = 4'(ARM_DELAY - 1);
    localparam logic [3:0] CNF_LAST = 4'(CONFIRM_CYCLES - 1);

    // With no exit delay, arming goes straight to ARMED.
    localparam state_t ARM_ENTRY   = (ARM_DELAY == 0) ? S_ARMED : S_ARMING;
    localparam logic   ENTRY_ARMED = (ARM_DELAY == 0);

    state_t     cur;
    logic [3:0] dly_cnt;
    logic [3:0] cnf_cnt;
    logic [2:0] zone_acc;

    logic [2:0] hit;
    logic       any_hit;
    logic [2:0] burst_zone;
    logic       burst_done;

    assign hit = {pir_sensor_3 >= THRESHOLD,
                  pir_sensor_2 >= THRESHOLD,
                  pir_sensor_1 >= THRESHOLD};
    assign any_hit = |hit;

    // cnf_cnt and zone_acc are always zero in ARMED. ARMED and CONFIRM can
    // therefore share one path: in ARMED the first hit yields count 1 and
    // zone = hit. With CONFIRM_CYCLES == 1, CNF_LAST is 0, so the first hit
    // raises the alarm at once.
    assign burst_zone = zone_acc | hit;
    assign burst_done = (cnf_cnt == CNF_LAST);

    assign state = cur;

    // NOTE: state and outputs update only with non-blocking assignments.
    // Every register therefore sees the pre-edge values of the others, and
    // the order of statements inside the block has no effect on the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            armed       <= 1'b0;
            alarm       <= 1'b0;
            zone        <= 3'b000;
            alarm_count <= 8'h00;
            dly_cnt     <= 4'd0;
            cnf_cnt     <= 4'd0;
            zone_acc    <= 3'b000;
        end else if (!turn) begin
            // Disarm wins over everything except reset. alarm_count is kept.
            cur      <= S_IDLE;
            armed    <= 1'b0;
            alarm    <= 1'b0;
            zone     <= 3'b000;
            dly_cnt  <= 4'd0;
            cnf_cnt  <= 4'd0;
            zone_acc <= 3'b000;
        end else begin
            unique case (cur)
                S_IDLE: begin
                    cur     <= ARM_ENTRY;
                    armed   <= ENTRY_ARMED;
                    dly_cnt <= 4'd0;
                end

                S_ARMING: begin
                    // Sensors are ignored during the exit delay.
                    if (dly_cnt == DLY_LAST) begin
                        cur     <= S_ARMED;
                        armed   <= 1'b1;
                        dly_cnt <= 4'd0;
                    end else begin
                        dly_cnt <= dly_cnt + 4'd1;
                    end
                end

                S_ARMED, S_CONFIRM: begin
                    if (!any_hit) begin
                        // A single quiet cycle restarts the run.
                        cur      <= S_ARMED;
                        cnf_cnt  <= 4'd0;
                        zone_acc <= 3'b000;
                    end else if (burst_done) begin
                        cur      <= S_ALARM;
                        alarm    <= 1'b1;
                        zone     <= burst_zone;
                        cnf_cnt  <= 4'd0;
                        zone_acc <= 3'b000;
                        if (alarm_count != 8'hFF) begin
                            alarm_count <= alarm_count + 8'd1;
                        end
                    end else begin
                        cur      <= S_CONFIRM;
                        cnf_cnt  <= cnf_cnt + 4'd1;
                        zone_acc <= burst_zone;
                    end
                end

                S_ALARM: begin
                    // Zone stays frozen until acknowledge. The full exit
                    // delay is applied again before re-arming.
                    if (stop_alarm) begin
                        cur     <= ARM_ENTRY;
                        armed   <= ENTRY_ARMED;
                        alarm   <= 1'b0;
                        zone    <= 3'b000;
                        dly_cnt <= 4'd0;
                    end
                end

                default: begin
                    cur      <= S_IDLE;
                    armed    <= 1'b0;
                    alarm    <= 1'b0;
                    zone     <= 3'b000;
                    dly_cnt  <= 4'd0;
                    cnf_cnt  <= 4'd0;
                    zone_acc <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_motion_alarm_ctrl
//
// Self-checking bench for motion_alarm_ctrl. A behavioural model tracks the
// following quantities:
//   - whether the system is enabled
//   - how many exit-delay cycles are left
//   - the length of the current motion run
//   - the alarm latch
// The expected debug state is derived from these quantities. A compare
// process checks every output against the model on each falling edge.
// Directed sequences pin the model with literal expectations. A randomized
// phase with occasional asynchronous resets follows.
// ---------------------------------------------------------------------------
module tb_motion_alarm_ctrl;

    localparam logic [6:0] THR = 7'd20;
    localparam int         CNF = 3;
    localparam int         DLY = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       turn;
    logic       stop_alarm;
    logic [6:0] s1, s2, s3;
    logic       armed;
    logic       alarm;
    logic [2:0] zone;
    logic [7:0] alarm_count;
    logic [2:0] state;

    motion_alarm_ctrl #(
        .THRESHOLD     (THR),
        .CONFIRM_CYCLES(CNF),
        .ARM_DELAY     (DLY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .turn        (turn),
        .stop_alarm  (stop_alarm),
        .pir_sensor_1(s1),
        .pir_sensor_2(s2),
        .pir_sensor_3(s3),
        .armed       (armed),
        .alarm       (alarm),
        .zone        (zone),
        .alarm_count (alarm_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit         m_on;
    int         m_arm_left;
    int         m_run;
    logic [2:0] m_rz;
    bit         m_alarm;
    logic [2:0] m_zone;
    int         m_count;

    function automatic int m_state();
        if (!m_on)              return 0;
        else if (m_arm_left > 0) return 1;
        else if (m_alarm)       return 4;
        else if (m_run > 0)     return 3;
        else                    return 2;
    endfunction

    task automatic model_reset();
        m_on = 0; m_arm_left = 0; m_run = 0; m_rz = '0;
        m_alarm = 0; m_zone = '0; m_count = 0;
    endtask

    task automatic model_step();
        logic [2:0] h;
        h = {s3 >= THR, s2 >= THR, s1 >= THR};
        if (!turn) begin
            m_on = 0; m_arm_left = 0; m_run = 0; m_rz = '0; m_alarm = 0; m_zone = '0;
        end else if (!m_on) begin
            m_on = 1; m_arm_left = DLY;
        end else if (m_arm_left > 0) begin
            m_arm_left--;
        end else if (m_alarm) begin
            if (stop_alarm) begin
                m_alarm = 0; m_zone = '0; m_arm_left = DLY;
            end
        end else if (h != 3'b000) begin
            m_run++;
            m_rz |= h;
            if (m_run == CNF) begin
                m_alarm = 1; m_zone = m_rz;
                if (m_count < 255) m_count++;
                m_run = 0; m_rz = '0;
            end
        end else begin
            m_run = 0; m_rz = '0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("outputs{state,armed,alarm,zone,count}",
                  {state, armed, alarm, zone, alarm_count},
                  {3'(m_state()), (m_state() >= 2), m_alarm, m_zone, 8'(m_count)});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at negedge+1; returns at the following negedge+1.
    task automatic step(input logic t, input logic st,
                        input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        turn = t; stop_alarm = st; s1 = a; s2 = b; s3 = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] rand_level();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return 7'd19;
            1:       return 7'd20;
            2, 3:    return 7'($urandom_range(21, 127));
            default: return 7'($urandom_range(0, 18));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0] lv [3];
        int         pick;

        // 1: reset with turn=1 and sensors saturated
        rst_n = 1'b0; turn = 1'b1; stop_alarm = 1'b0;
        s1 = 7'd127; s2 = 7'd127; s3 = 7'd127;
        model_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        check("reset_outputs", {state, armed, alarm, zone, alarm_count}, 16'h0000);
        rst_n = 1'b1;

        // 2: exit delay of two cycles, then ARMED; quiet sensors never alarm
        step(1, 0, 0, 0, 0);
        check("arming_first", state, 3'd1);
        step(1, 0, 0, 0, 0);
        check("arming_second", {state, armed}, {3'd1, 1'b0});
        step(1, 0, 0, 0, 0);
        check("armed_reached", {state, armed}, {3'd2, 1'b1});
        repeat (20) step(1, 0, 0, 0, 0);
        check("quiet_no_alarm", {state, alarm}, {3'd2, 1'b0});

        // 3: sensor_1=29, sensor_3=56 -> alarm after the 3rd sample
        step(1, 0, 29, 0, 56);
        step(1, 0, 29, 0, 56);
        check("confirm_no_alarm_yet", {state, alarm}, {3'd3, 1'b0});
        step(1, 0, 29, 0, 56);
        check("alarm_raised", {state, alarm, zone, alarm_count}, {3'd4, 1'b1, 3'b101, 8'd1});
        step(1, 0, 29, 0, 56);
        step(1, 0, 29, 0, 56);
        repeat (3) step(1, 0, 0, 0, 0);
        check("alarm_holds", {alarm, zone}, {1'b1, 3'b101});

        // 5: acknowledge -> ARMING for 2 cycles, then ARMED
        step(1, 1, 0, 0, 0);
        check("ack_clears", {state, alarm, zone}, {3'd1, 1'b0, 3'b000});
        step(1, 0, 0, 0, 0);
        check("ack_arming_second", state, 3'd1);
        step(1, 0, 0, 0, 0);
        check("ack_rearmed", state, 3'd2);

        // 4: broken run never alarms; level 19 is below threshold
        step(1, 0, 0, 20, 0);
        step(1, 0, 0, 20, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 20, 0);
        step(1, 0, 0, 20, 0);
        check("broken_run_no_alarm", {state, alarm}, {3'd3, 1'b0});
        step(1, 0, 0, 0, 0);
        repeat (10) step(1, 0, 0, 19, 0);
        check("level_19_no_alarm", {state, alarm, alarm_count}, {3'd2, 1'b0, 8'd1});

        // 5b: acknowledge together with disarm -> IDLE
        repeat (3) step(1, 0, 127, 0, 0);
        check("second_alarm", {alarm, zone, alarm_count}, {1'b1, 3'b001, 8'd2});
        step(0, 1, 0, 0, 0);
        check("ack_and_disarm_idle", {state, alarm, alarm_count}, {3'd0, 1'b0, 8'd2});

        // 6b: disarm during CONFIRM
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 50, 50, 50);
        step(1, 0, 50, 50, 50);
        check("in_confirm", state, 3'd3);
        step(0, 0, 50, 50, 50);
        check("disarm_in_confirm", {state, alarm, zone}, {3'd0, 1'b0, 3'b000});

        // 6: saturate alarm_count with random zone patterns
        repeat (3) step(1, 0, 0, 0, 0);
        for (int n = 0; n < 260; n++) begin
            for (int k = 0; k < CNF; k++) begin
                pick = $urandom_range(0, 2);
                for (int z = 0; z < 3; z++) begin
                    if (z == pick || $urandom_range(0, 1) == 1) lv[z] = 7'($urandom_range(20, 127));
                    else lv[z] = 7'($urandom_range(0, 19));
                end
                step(1, 0, lv[0], lv[1], lv[2]);
            end
            step(1, 1, 0, 0, 0);
            repeat (DLY) step(1, 0, 0, 0, 0);
        end
        check("count_saturated", alarm_count, 8'hFF);

        // Randomized phase with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                step(($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 8),
                     rand_level(), rand_level(), rand_level());
            end
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
